// File: rtl/multi_clock_divider.sv
// ============================================================================
//  Module   : multi_clock_divider
//  Purpose  : NUM_CH independent glitch-free 50%-duty clock dividers with
//             runtime-programmable half-periods and per-channel rise ticks.
//             Optional macro CLKDIV_SYNC_EN adds sync_in for phase alignment.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_clock_divider #(
    parameter int NUM_CH     = 4,
    parameter int CH_IDX_W   = 2,
    parameter int DIV_SIZE   = 15,
    parameter int RESET_HALF = 24000
) (
    input  logic                clock_in,
    input  logic                reset_b,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync_in,
`endif
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [DIV_SIZE-1:0] wr_data,
    output logic [NUM_CH-1:0]   clock_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   running
);

    localparam logic [DIV_SIZE-1:0] C_RESET_HALF = DIV_SIZE'(RESET_HALF);
    localparam logic [DIV_SIZE-1:0] C_ONE        = DIV_SIZE'(1);
    localparam logic [DIV_SIZE-1:0] C_ZERO       = '0;

    logic [DIV_SIZE-1:0] pend_q [NUM_CH];
    logic [DIV_SIZE-1:0] pend_d [NUM_CH];
    logic [DIV_SIZE-1:0] act_q  [NUM_CH];
    logic [DIV_SIZE-1:0] act_d  [NUM_CH];
    logic [DIV_SIZE-1:0] cnt_q  [NUM_CH];
    logic [DIV_SIZE-1:0] cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]   clk_q;
    logic [NUM_CH-1:0]   clk_d;
    logic [NUM_CH-1:0]   tick_q;
    logic [NUM_CH-1:0]   tick_d;
    logic [NUM_CH-1:0]   running_q;
    logic [NUM_CH-1:0]   running_d;
    logic                sync_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pend_d[i]    = pend_q[i];
            act_d[i]     = act_q[i];
            cnt_d[i]     = cnt_q[i];
            clk_d[i]     = clk_q[i];
            tick_d[i]    = 1'b0;

            // Out-of-range channel indices simply never match.
            if (wr_en && (wr_ch == CH_IDX_W'(i))) begin
                pend_d[i] = wr_data;
            end

            if (sync_w) begin
                cnt_d[i] = C_ZERO;
                clk_d[i] = 1'b0;
                act_d[i] = pend_q[i];
            end else if (act_q[i] == C_ZERO) begin
                cnt_d[i] = C_ZERO;
                clk_d[i] = 1'b0;
                if (pend_q[i] != C_ZERO) begin
                    act_d[i] = pend_q[i];
                end
            end else if (cnt_q[i] == (act_q[i] - C_ONE)) begin
                cnt_d[i] = C_ZERO;
                if (clk_q[i]) begin
                    clk_d[i] = 1'b0;
                end else begin
                    // Period boundary: the only point a new half-period is adopted.
                    act_d[i] = pend_q[i];
                    if (pend_q[i] != C_ZERO) begin
                        clk_d[i]  = 1'b1;
                        tick_d[i] = 1'b1;
                    end
                end
            end else begin
                cnt_d[i] = cnt_q[i] + C_ONE;
            end

            running_d[i] = (act_d[i] != C_ZERO);
        end
    end

    always_ff @(posedge clock_in or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= C_RESET_HALF;
                act_q[i]  <= C_RESET_HALF;
                cnt_q[i]  <= C_ZERO;
            end
            clk_q     <= '0;
            tick_q    <= '0;
            running_q <= {NUM_CH{C_RESET_HALF != C_ZERO}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= pend_d[i];
                act_q[i]  <= act_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    assign clock_out = clk_q;
    assign tick      = tick_q;
    assign running   = running_q;

endmodule

`default_nettype wire
